decode_regread: RTL and testbench
=================================

Name: decode_regread

Overview:
- Decode/register-read stage sitting directly upstream of the SPARC ALU.
- Accepts a fetched 32-bit instruction plus its PC and splits it into the SPARC format fields the ALU consumes.
- Reads rs1/rs2/rd from a 32-entry integer register file (no windows); the write port is driven by writeback.
- Holds the result in a valid/ready pipeline register with flush support.

Parameters:
- NREGS, 32, number of architectural integer registers; r0 is hardwired to zero.
- XLEN, 32, data and PC width.

Ports:
- DRR_clk_in  input  1  clock; all state updates on the rising edge.
- DRR_reset_in  input  1  synchronous, active-high reset.
- DRR_inst_in  input  32  instruction word from fetch.
- DRR_PC_in  input  32  PC of DRR_inst_in.
- DRR_valid_in  input  1  fetch has a valid instruction.
- DRR_ready_out  output  1  stage can accept an instruction this cycle.
- DRR_flush_in  input  1  kill the held instruction (branch redirect).
- DRR_wb_en_in  input  1  writeback write enable.
- DRR_wb_rd_in  input  5  writeback destination register.
- DRR_wb_data_in  input  32  writeback data.
- DRR_valid_out  output  1  outputs hold a valid decoded instruction.
- DRR_ready_in  input  1  ALU/downstream accepts this cycle.
- DRR_op_out 2, DRR_op2_out 3, DRR_op3_out 6, DRR_rd_out 5, DRR_a_out 1, DRR_cond_out 4, DRR_i_out 1, DRR_simm13_out 13, DRR_imm22_out 22, DRR_disp30_out 30  outputs  decoded fields.
- DRR_valA_out  output  32  value of rs1.
- DRR_valB_out  output  32  value of rs2.
- DRR_valC_out  output  32  value of rd (store data).
- DRR_PC_out  output  32  PC of the held instruction.

Behaviour:
- Field slicing:
  - op = inst[31:30], rd = [29:25], a = [29], cond = [28:25], op2 = [24:22], imm22 = [21:0], disp30 = [29:0].
  - op3 = [24:19], rs1 = [18:14], i = [13], simm13 = [12:0], rs2 = [4:0].
  - All fields are sliced regardless of format; the consumer selects by op.
- Register read: combinational from the array, captured into the output register. Reading r0 always yields 0.
- Register write: on the clock edge when wb_en=1 and wb_rd≠0. Writes to r0 are dropped.
- Handshake:
  - DRR_ready_out = DRR_ready_in | ~DRR_valid_out (combinational). No bubble on back-to-back instructions.
  - Load condition: valid_in & ready_out & ~flush. On load, capture all fields, the three read values and PC, and set valid_out=1.
  - If ready_in=1 and no load occurs, valid_out drops to 0.
  - If valid_out=1 and ready_in=0, every output holds stable.
- Flush: valid_out goes to 0 on the next edge and overrides a simultaneous load; the input instruction is not consumed. The register file is unaffected; writeback in the same cycle still commits.
- Reset:
  - valid_out=0, all field/value/PC outputs = 0, all registers = 0.
  - Reset overrides flush, load and writeback in the same cycle.
  - A mid-stall reset discards the held instruction.
- Latency: 1 cycle from accept to valid_out.
- Data hazards: no scoreboard. Hazards against instructions already downstream are resolved by later forwarding.

Optional Feature:
- Macro DRR_WB_BYPASS_EN.
- Defined: if wb_en=1, wb_rd≠0 and wb_rd matches rs1/rs2/rd of the instruction being loaded, the captured value is wb_data (write-before-read).
- Undefined: the captured value is the pre-write array contents. Software or later forwarding must cover the one-cycle gap.

Test Plan:
- Reset, then write r5=0x0000_00A5 via writeback; load ADD r3,r5,r0 (inst 0x8601_4000) -> next cycle valid_out=1, op=2, op3=0x00, rd=3, valA=0xA5, valB=0.
- Load SETHI 0x3FFFFF,r1 (inst 0x033F_FFFF), PC 0x40 -> op=0, op2=4, imm22=0x3FFFFF, rd=1, PC_out=0x40.
- Writeback r0=0xDEADBEEF, then read rs1=r0 -> valA=0.
- Hold ready_in=0 for 3 cycles with valid_in=1 -> outputs stable, ready_out=0; release -> next instruction loads on the first cycle ready_in=1.
- Assert flush with valid_in=1 -> valid_out=0 next cycle; a writeback r7=0x11 in the same cycle is visible on a later read of r7.
- Write r9=0x1234 on the same edge an instruction reading rs1=r9 loads -> valA=0x1234 with DRR_WB_BYPASS_EN defined, old value (0) without it.

Source files
------------

// File: rtl/decode_regread.sv
// Decode/register-read stage feeding the SPARC ALU: field slicing, 32-entry integer
// register file read, valid/ready output register with flush. Optional macro: DRR_WB_BYPASS_EN.
module decode_regread #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            DRR_clk_in,
    input  logic            DRR_reset_in,
    input  logic [31:0]     DRR_inst_in,
    input  logic [XLEN-1:0] DRR_PC_in,
    input  logic            DRR_valid_in,
    output logic            DRR_ready_out,
    input  logic            DRR_flush_in,
    input  logic            DRR_wb_en_in,
    input  logic [4:0]      DRR_wb_rd_in,
    input  logic [XLEN-1:0] DRR_wb_data_in,
    output logic            DRR_valid_out,
    input  logic            DRR_ready_in,
    output logic [1:0]      DRR_op_out,
    output logic [2:0]      DRR_op2_out,
    output logic [5:0]      DRR_op3_out,
    output logic [4:0]      DRR_rd_out,
    output logic            DRR_a_out,
    output logic [3:0]      DRR_cond_out,
    output logic            DRR_i_out,
    output logic [12:0]     DRR_simm13_out,
    output logic [21:0]     DRR_imm22_out,
    output logic [29:0]     DRR_disp30_out,
    output logic [XLEN-1:0] DRR_valA_out,
    output logic [XLEN-1:0] DRR_valB_out,
    output logic [XLEN-1:0] DRR_valC_out,
    output logic [XLEN-1:0] DRR_PC_out
);

    logic [XLEN-1:0] regs [NREGS];

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            wb_commit;
    logic            load;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [XLEN-1:0] val_c;

    assign rs1 = DRR_inst_in[18:14];
    assign rs2 = DRR_inst_in[4:0];
    assign rd  = DRR_inst_in[29:25];

    assign wb_commit     = DRR_wb_en_in && (DRR_wb_rd_in != 5'd0);
    assign DRR_ready_out = DRR_ready_in || !DRR_valid_out;
    assign load          = DRR_valid_in && DRR_ready_out && !DRR_flush_in;

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0) begin
`ifdef DRR_WB_BYPASS_EN
            if (wb_commit && (DRR_wb_rd_in == idx))
                v = DRR_wb_data_in;
            else
                v = regs[idx];
`else
            v = regs[idx];
`endif
        end
        return v;
    endfunction

    always_comb begin
        val_a = read_port(rs1);
        val_b = read_port(rs2);
        val_c = read_port(rd);
    end

    always_ff @(posedge DRR_clk_in) begin
        if (DRR_reset_in) begin
            for (int k = 0; k < NREGS; k++)
                regs[k] <= '0;
            DRR_valid_out  <= 1'b0;
            DRR_op_out     <= '0;
            DRR_op2_out    <= '0;
            DRR_op3_out    <= '0;
            DRR_rd_out     <= '0;
            DRR_a_out      <= 1'b0;
            DRR_cond_out   <= '0;
            DRR_i_out      <= 1'b0;
            DRR_simm13_out <= '0;
            DRR_imm22_out  <= '0;
            DRR_disp30_out <= '0;
            DRR_valA_out   <= '0;
            DRR_valB_out   <= '0;
            DRR_valC_out   <= '0;
            DRR_PC_out     <= '0;
        end else begin
            // r0 is never written, so it stays at its reset value of zero
            if (wb_commit)
                regs[DRR_wb_rd_in] <= DRR_wb_data_in;

            if (DRR_flush_in) begin
                DRR_valid_out <= 1'b0;
            end else if (load) begin
                DRR_valid_out  <= 1'b1;
                DRR_op_out     <= DRR_inst_in[31:30];
                DRR_op2_out    <= DRR_inst_in[24:22];
                DRR_op3_out    <= DRR_inst_in[24:19];
                DRR_rd_out     <= DRR_inst_in[29:25];
                DRR_a_out      <= DRR_inst_in[29];
                DRR_cond_out   <= DRR_inst_in[28:25];
                DRR_i_out      <= DRR_inst_in[13];
                DRR_simm13_out <= DRR_inst_in[12:0];
                DRR_imm22_out  <= DRR_inst_in[21:0];
                DRR_disp30_out <= DRR_inst_in[29:0];
                DRR_valA_out   <= val_a;
                DRR_valB_out   <= val_b;
                DRR_valC_out   <= val_c;
                DRR_PC_out     <= DRR_PC_in;
            end else if (DRR_ready_in) begin
                DRR_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_regread.sv
// Scoreboard bench for decode_regread: directed instructions push expected results,
// a negedge monitor pops and compares on every downstream transfer.
module tb_decode_regread;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid_in;
    logic        ready_out;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid_out;
    logic        ready_in;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic        a;
    logic [3:0]  cond;
    logic        i_bit;
    logic [12:0] simm13;
    logic [21:0] imm22;
    logic [29:0] disp30;
    logic [31:0] val_a;
    logic [31:0] val_b;
    logic [31:0] val_c;
    logic [31:0] pc_out;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    decode_regread dut (
        .DRR_clk_in(clk),
        .DRR_reset_in(rst),
        .DRR_inst_in(inst),
        .DRR_PC_in(pc),
        .DRR_valid_in(valid_in),
        .DRR_ready_out(ready_out),
        .DRR_flush_in(flush),
        .DRR_wb_en_in(wb_en),
        .DRR_wb_rd_in(wb_rd),
        .DRR_wb_data_in(wb_data),
        .DRR_valid_out(valid_out),
        .DRR_ready_in(ready_in),
        .DRR_op_out(op),
        .DRR_op2_out(op2),
        .DRR_op3_out(op3),
        .DRR_rd_out(rd),
        .DRR_a_out(a),
        .DRR_cond_out(cond),
        .DRR_i_out(i_bit),
        .DRR_simm13_out(simm13),
        .DRR_imm22_out(imm22),
        .DRR_disp30_out(disp30),
        .DRR_valA_out(val_a),
        .DRR_valB_out(val_b),
        .DRR_valC_out(val_c),
        .DRR_PC_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_pc=0x%08h required=none", pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("op",     {30'd0, op},     {30'd0, e.inst[31:30]});
                chk("op2",    {29'd0, op2},    {29'd0, e.inst[24:22]});
                chk("op3",    {26'd0, op3},    {26'd0, e.inst[24:19]});
                chk("rd",     {27'd0, rd},     {27'd0, e.inst[29:25]});
                chk("a",      {31'd0, a},      {31'd0, e.inst[29]});
                chk("cond",   {28'd0, cond},   {28'd0, e.inst[28:25]});
                chk("i",      {31'd0, i_bit},  {31'd0, e.inst[13]});
                chk("simm13", {19'd0, simm13}, {19'd0, e.inst[12:0]});
                chk("imm22",  {10'd0, imm22},  {10'd0, e.inst[21:0]});
                chk("disp30", {2'd0, disp30},  {2'd0, e.inst[29:0]});
                chk("valA",   val_a,  e.va);
                chk("valB",   val_b,  e.vb);
                chk("valC",   val_c,  e.vc);
                chk("pc",     pc_out, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic idle();
        valid_in = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    // Only used where the stage is known to accept this cycle
    task automatic issue(input logic [31:0] i_w, input logic [31:0] p,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
        exp_t e;
        e.inst = i_w; e.pc = p; e.va = va; e.vb = vb; e.vc = vc;
        sb.push_back(e);
        inst = i_w; pc = p; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    initial begin
        logic [31:0] snap_pc, snap_a, snap_b;
        logic [31:0] r9_exp;
        int wait_cnt;

        rst = 1'b1; inst = '0; pc = '0; valid_in = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid",  {31'd0, valid_out}, 32'd0);
        chk("rst_ready",  {31'd0, ready_out}, 32'd1);
        chk("rst_pc",     pc_out, 32'd0);
        chk("rst_valA",   val_a, 32'd0);
        chk("rst_disp30", {2'd0, disp30}, 32'd0);

        wb_write(5'd5, 32'h0000_00A5);
        // Back-to-back: ADD r3,r5,r0 then SETHI 0x3FFFFF,r1
        issue(32'h8601_4000, 32'h0000_0100, 32'h0000_00A5, 32'd0, 32'd0);
        issue(32'h033F_FFFF, 32'h0000_0040, 32'd0, 32'd0, 32'd0);

        wb_write(5'd0, 32'hDEAD_BEEF);
        // ADD r2,r0,r5
        issue(32'h8400_0005, 32'h0000_0104, 32'd0, 32'h0000_00A5, 32'd0);
        @(posedge clk); #1;

        // Stall: X loads into an empty stage, then Y waits behind it
        ready_in = 1'b0;
        issue(32'h8A00_0005, 32'h0000_0200, 32'd0, 32'h0000_00A5, 32'h0000_00A5);
        snap_pc = pc_out; snap_a = val_a; snap_b = val_b;
        chk("stall_loaded_pc", pc_out, 32'h0000_0200);
        inst = 32'h8400_0005; pc = 32'h0000_0204; valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_ready_out", {31'd0, ready_out}, 32'd0);
            chk("stall_valid",     {31'd0, valid_out}, 32'd1);
            chk("stall_pc",        pc_out, snap_pc);
            chk("stall_valB",      val_b, snap_b);
            chk("stall_valA",      val_a, snap_a);
        end
        begin
            exp_t e;
            e.inst = 32'h8400_0005; e.pc = 32'h0000_0204;
            e.va = 32'd0; e.vb = 32'h0000_00A5; e.vc = 32'd0;
            sb.push_back(e);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("release_first_cycle_pc", pc_out, 32'h0000_0204);
        @(posedge clk); #1;

        // Flush with a valid instruction and a same-cycle writeback of r7
        inst = 32'h8600_0000; pc = 32'h0000_0300; valid_in = 1'b1; flush = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0011;
        @(posedge clk); #1;
        idle();
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        // ADD r1,r7,r0
        issue(32'h8201_C000, 32'h0000_0304, 32'h0000_0011, 32'd0, 32'd0);

        // r9 written on the same edge that ADD r4,r9,r0 loads
`ifdef DRR_WB_BYPASS_EN
        r9_exp = 32'h0000_1234;
`else
        r9_exp = 32'd0;
`endif
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_1234;
        issue(32'h8802_4000, 32'h0000_0400, r9_exp, 32'd0, 32'd0);
        wb_en = 1'b0;
        issue(32'h8802_4000, 32'h0000_0404, 32'h0000_1234, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Mid-stall reset discards the held instruction and clears the file
        ready_in = 1'b0;
        inst = 32'h8601_4000; pc = 32'h0000_0500; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("pre_reset_valid", {31'd0, valid_out}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_reset_pc",    pc_out, 32'd0);
        ready_in = 1'b1;
        issue(32'h8601_4000, 32'h0000_0600, 32'd0, 32'd0, 32'd0);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
